oled_link_scheduler: RTL and testbench

- Shares the single OLED serial link between two hardware requesters: 0 = init/command sequencer, 1 = frame refresh engine.
- Arbitrates between them round-robin, with an optional lock that holds the link for one requester across a burst.
- Issues one word per transfer to the OLED serialiser and waits for its completion pulse.
- Enforces a minimum inter-transfer gap and a completion watchdog.

---
 rtl/oled_link_scheduler.sv | 174 +++++++++++++++++
 tb/tb_oled_link_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_link_scheduler.sv
// oled_link_scheduler
//   Shares one OLED serial link between two requesters
//   (0 = init/command sequencer, 1 = frame refresh engine).
//   - Round-robin arbitration, with an optional per-word lock that keeps the
//     grant with the current owner across a burst.
//   - One word is issued per transfer, then the block waits for the
//     serialiser's completion pulse.
//   - A watchdog aborts the transfer if completion never arrives.
//   - A fixed idle gap follows every completed or aborted transfer.
//
// Parameters
//   GAP      idle cycles after each transfer (0..15, 0 = straight to IDLE)
//   TIMEOUT  max cycles in WAIT before abort (1..255)
//
// Ports
//   HCLK, HRESET          clock, async active-high reset
//   reqN/dncN/dataN/lockN requester N request, D/nC, payload, burst lock
//   ackN                  one-cycle pulse: requester N word captured
//   tx_start/tx_dnc/tx_data  serialiser launch pulse and latched word
//   tx_done               serialiser completion pulse (honoured in WAIT only)
//   busy, owner           state != IDLE, current or last grant
//   timeout_err, err_clr  sticky watchdog flag and its clear
//
// Build option
//   OLED_SCHED_STATS_EN   adds cnt0/cnt1 completed-transfer counters
module oled_link_scheduler #(
  parameter int GAP     = 2,
  parameter int TIMEOUT = 64
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        req0,
  input  logic        dnc0,
  input  logic [15:0] data0,
  input  logic        lock0,
  output logic        ack0,
  input  logic        req1,
  input  logic        dnc1,
  input  logic [15:0] data1,
  input  logic        lock1,
  output logic        ack1,
  output logic        tx_start,
  output logic        tx_dnc,
  output logic [15:0] tx_data,
  input  logic        tx_done,
  output logic        busy,
  output logic        owner,
  output logic        timeout_err,
  input  logic        err_clr
`ifdef OLED_SCHED_STATS_EN
  ,
  output logic [15:0] cnt0,
  output logic [15:0] cnt1
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

  localparam logic [7:0] WD_LAST    = 8'(TIMEOUT - 1);
  localparam logic [3:0] GAP_LD     = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
  localparam state_t     AFTER_WAIT = (GAP == 0) ? S_IDLE : S_GAP;

  state_t      state, nxt;
  logic        last_grant, lock_active;
  logic [7:0]  wd_cnt;
  logic [3:0]  gap_cnt;
  logic        lock_hold, win_vld, win;
  logic        accept, done_ok, wd_expire;

  // Arbitration. A held lock bypasses round-robin entirely; a stale lock
  // (owner dropped req) falls through to normal arbitration this same cycle.
  always_comb begin
    lock_hold = lock_active && (owner ? req1 : req0);
    win_vld   = 1'b0;
    win       = 1'b0;
    if (lock_hold) begin
      win_vld = 1'b1;
      win     = owner;
    end else if (req0 && req1) begin
      win_vld = 1'b1;
      win     = ~last_grant;
    end else if (req0) begin
      win_vld = 1'b1;
      win     = 1'b0;
    end else if (req1) begin
      win_vld = 1'b1;
      win     = 1'b1;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= S_IDLE;
    else        state <= nxt;
  end

  // tx_done takes priority over the watchdog on the final WAIT cycle.
  always_comb begin
    nxt       = state;
    accept    = 1'b0;
    done_ok   = 1'b0;
    wd_expire = 1'b0;
    case (state)
      S_IDLE:  if (win_vld) begin
                 accept = 1'b1;
                 nxt    = S_ISSUE;
               end
      S_ISSUE: nxt = S_WAIT;
      S_WAIT:  if (tx_done) begin
                 done_ok = 1'b1;
                 nxt     = AFTER_WAIT;
               end else if (wd_cnt == WD_LAST) begin
                 wd_expire = 1'b1;
                 nxt       = AFTER_WAIT;
               end
      S_GAP:   if (gap_cnt == 4'd0) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decode straight from registered state, so an async
  // reset drops them with no glitch.
  assign tx_start = (state == S_ISSUE);
  assign ack0     = tx_start && !owner;
  assign ack1     = tx_start &&  owner;
  assign busy     = (state != S_IDLE);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      tx_dnc      <= 1'b0;
      tx_data     <= 16'h0000;
      owner       <= 1'b0;
      last_grant  <= 1'b1;  // req0 wins the first tie
      lock_active <= 1'b0;
      wd_cnt      <= 8'd0;
      gap_cnt     <= 4'd0;
      timeout_err <= 1'b0;
    end else begin
      if (accept) begin
        tx_dnc      <= win ? dnc1  : dnc0;
        tx_data     <= win ? data1 : data0;
        owner       <= win;
        last_grant  <= win;
        lock_active <= win ? lock1 : lock0;
      end else if (state == S_IDLE && lock_active && !lock_hold) begin
        lock_active <= 1'b0;
      end else if (wd_expire) begin
        lock_active <= 1'b0;
      end

      if (state == S_ISSUE)     wd_cnt <= 8'd0;
      else if (state == S_WAIT) wd_cnt <= wd_cnt + 8'd1;

      if (done_ok || wd_expire)                      gap_cnt <= GAP_LD;
      else if (state == S_GAP && gap_cnt != 4'd0)    gap_cnt <= gap_cnt - 4'd1;

      // Set wins over a coincident clear.
      if (wd_expire)    timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

`ifdef OLED_SCHED_STATS_EN
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      cnt0 <= 16'h0000;
      cnt1 <= 16'h0000;
    end else if (done_ok) begin
      if (owner) cnt1 <= cnt1 + 16'h0001;
      else       cnt0 <= cnt0 + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_oled_link_scheduler.sv
// Directed bench for oled_link_scheduler (GAP=2, TIMEOUT=64).
module tb_oled_link_scheduler;

  localparam int TO = 64;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b0;
  logic        req0 = 0, dnc0 = 0, lock0 = 0, req1 = 0, dnc1 = 0, lock1 = 0;
  logic [15:0] data0 = 0, data1 = 0;
  logic        ack0, ack1, tx_start, tx_dnc, busy, owner, timeout_err;
  logic [15:0] tx_data;
  logic        tx_done = 0, err_clr = 0;
`ifdef OLED_SCHED_STATS_EN
  logic [15:0] cnt0, cnt1;
`endif

  int checks = 0;
  int errors = 0;

  oled_link_scheduler #(.GAP(2), .TIMEOUT(TO)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req0(req0), .dnc0(dnc0), .data0(data0), .lock0(lock0), .ack0(ack0),
    .req1(req1), .dnc1(dnc1), .data1(data1), .lock1(lock1), .ack1(ack1),
    .tx_start(tx_start), .tx_dnc(tx_dnc), .tx_data(tx_data), .tx_done(tx_done),
    .busy(busy), .owner(owner), .timeout_err(timeout_err), .err_clr(err_clr)
`ifdef OLED_SCHED_STATS_EN
    , .cnt0(cnt0), .cnt1(cnt1)
`endif
  );

  always #5 HCLK = ~HCLK;

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic wait_ack(output logic g0, output logic g1, output bit ok);
    ok = 0; g0 = 0; g1 = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (ack0 || ack1) begin
        ok = 1; g0 = ack0; g1 = ack1;
        break;
      end
    end
  endtask

  // Called at the ISSUE-cycle sample point: completes the word and returns at IDLE.
  task automatic serve;
    tick;
    tx_done = 1;
    tick;
    tx_done = 0;
    tick;
    tick;
  endtask

  task automatic do_reset;
    HRESET = 1;
    tick;
    HRESET = 0;
  endtask

  task automatic test_reset;
    HRESET = 1;
    tick;
    checks++;
    if ({ack0, ack1, tx_start, tx_dnc, busy, owner, timeout_err} !== 7'b0 || tx_data !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: got %b/%h want 0000000/0000",
               {ack0, ack1, tx_start, tx_dnc, busy, owner, timeout_err}, tx_data);
    end
    HRESET = 0;
  endtask

  task automatic test_single;
    req0 = 1; dnc0 = 0; data0 = 16'h00AF;
    tick;
    checks++;
    if ({ack0, ack1, tx_start, busy, owner} !== 5'b10110 || tx_data !== 16'h00AF || tx_dnc !== 1'b0) begin
      errors++;
      $display("FAIL single_issue: ack0/ack1/start/busy/owner=%b data=%h dnc=%b want 10110 00af 0",
               {ack0, ack1, tx_start, busy, owner}, tx_data, tx_dnc);
    end
    req0 = 0;
    tick;
    checks++;
    if (tx_start !== 1'b0 || ack0 !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_wait: start=%b ack0=%b busy=%b want 0 0 1", tx_start, ack0, busy);
    end
    repeat (3) tick;
    tx_done = 1;
    tick;
    tx_done = 0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL single_gap1: busy=%b want 1", busy); end
    tick;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL single_gap2: busy=%b want 1", busy); end
    tick;
    checks++;
    if (busy !== 1'b0 || tx_data !== 16'h00AF) begin
      errors++;
      $display("FAIL single_idle: busy=%b data=%h want 0 00af", busy, tx_data);
    end
  endtask

  task automatic test_round_robin;
    logic g0, g1, exp;
    bit ok;
    do_reset;
    req0 = 1; req1 = 1; lock0 = 0; lock1 = 0;
    data0 = 16'h00A0; data1 = 16'h00B1; dnc0 = 1; dnc1 = 0;
    for (int k = 0; k < 4; k++) begin
      exp = k[0];
      wait_ack(g0, g1, ok);
      checks++;
      if (!ok || (g0 && g1) || g1 !== exp || g0 !== !exp || owner !== exp ||
          tx_data !== (exp ? 16'h00B1 : 16'h00A0)) begin
        errors++;
        $display("FAIL rr_grant%0d: ok=%0d ack0=%b ack1=%b owner=%b data=%h want owner %b",
                 k, ok, g0, g1, owner, tx_data, exp);
      end
      serve;
    end
    req0 = 0; req1 = 0;
  endtask

  task automatic test_lock;
    logic g0, g1;
    bit ok;
    do_reset;
    req1 = 1; lock1 = 1; data1 = 16'h0101;
    wait_ack(g0, g1, ok);
    checks++;
    if (!ok || g1 !== 1'b1 || tx_data !== 16'h0101) begin
      errors++;
      $display("FAIL lock_w1: ok=%0d ack1=%b data=%h want 1 0101", ok, g1, tx_data);
    end
    req0 = 1; data0 = 16'h0A0A; data1 = 16'h0102;
    serve;
    wait_ack(g0, g1, ok);
    checks++;
    if (!ok || g1 !== 1'b1 || g0 !== 1'b0 || tx_data !== 16'h0102) begin
      errors++;
      $display("FAIL lock_w2: ok=%0d ack0=%b ack1=%b data=%h want 0 1 0102", ok, g0, g1, tx_data);
    end
    data1 = 16'h0103; lock1 = 0;
    serve;
    wait_ack(g0, g1, ok);
    checks++;
    if (!ok || g1 !== 1'b1 || g0 !== 1'b0 || tx_data !== 16'h0103) begin
      errors++;
      $display("FAIL lock_w3: ok=%0d ack0=%b ack1=%b data=%h want 0 1 0103", ok, g0, g1, tx_data);
    end
    serve;
    wait_ack(g0, g1, ok);
    checks++;
    if (!ok || g0 !== 1'b1 || g1 !== 1'b0 || tx_data !== 16'h0A0A || owner !== 1'b0) begin
      errors++;
      $display("FAIL lock_release: ok=%0d ack0=%b ack1=%b data=%h owner=%b want 1 0 0a0a 0",
               ok, g0, g1, tx_data, owner);
    end
    req0 = 0; req1 = 0;
    serve;
  endtask

  task automatic test_timeout;
    do_reset;
    req0 = 1; data0 = 16'h0055;
    tick;
    req0 = 0;
    tick;                       // entered WAIT
    repeat (TO - 1) tick;
    checks++;
    if (timeout_err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: err=%b busy=%b want 0 1", timeout_err, busy);
    end
    err_clr = 1;                // coincident clear loses to set
    tick;
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_set: err=%b want 1", timeout_err);
    end
    tick;
    err_clr = 0;
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: err=%b want 0", timeout_err);
    end
    tick;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL timeout_idle: busy=%b want 0", busy); end
    req1 = 1; data1 = 16'h1234; dnc1 = 1;
    tick;
    checks++;
    if (ack1 !== 1'b1 || tx_start !== 1'b1 || tx_data !== 16'h1234 || tx_dnc !== 1'b1) begin
      errors++;
      $display("FAIL timeout_next: ack1=%b start=%b data=%h dnc=%b want 1 1 1234 1",
               ack1, tx_start, tx_data, tx_dnc);
    end
    req1 = 0;
    serve;
    checks++;
    if (timeout_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_after: err=%b busy=%b want 0 0", timeout_err, busy);
    end
  endtask

  task automatic test_last_cycle_done;
    do_reset;
    req0 = 1; data0 = 16'h0077;
    tick;
    req0 = 0;
    tick;
    repeat (TO - 1) tick;
    tx_done = 1;                // final watchdog cycle
    tick;
    checks++;
    if (timeout_err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL last_cycle_done: err=%b busy=%b want 0 1", timeout_err, busy);
    end
    tick;                       // stray tx_done in GAP
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL stray_gap: busy=%b want 1", busy); end
    tick;
    tick;                       // stray tx_done in IDLE
    tx_done = 0;
    checks++;
    if (busy !== 1'b0 || tx_start !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL stray_idle: busy=%b start=%b err=%b want 0 0 0", busy, tx_start, timeout_err);
    end
  endtask

  task automatic test_reset_mid_wait;
    do_reset;
    req1 = 1; dnc1 = 1; data1 = 16'hBEEF;
    tick;
    req1 = 0;
    tick;
    checks++;
    if (busy !== 1'b1 || owner !== 1'b1 || tx_data !== 16'hBEEF) begin
      errors++;
      $display("FAIL pre_reset: busy=%b owner=%b data=%h want 1 1 beef", busy, owner, tx_data);
    end
    #2 HRESET = 1;
    #1;
    checks++;
    if ({ack0, ack1, tx_start, tx_dnc, busy, owner, timeout_err} !== 7'b0 || tx_data !== 16'h0) begin
      errors++;
      $display("FAIL async_reset: got %b/%h want 0000000/0000",
               {ack0, ack1, tx_start, tx_dnc, busy, owner, timeout_err}, tx_data);
    end
    tick;
    HRESET = 0;
  endtask

`ifdef OLED_SCHED_STATS_EN
  task automatic test_stats;
    do_reset;
    for (int k = 0; k < 5; k++) begin
      if (k < 3) begin req0 = 1; data0 = 16'(k); end
      else       begin req1 = 1; data1 = 16'(k); end
      tick;
      req0 = 0; req1 = 0;
      serve;
    end
    checks++;
    if (cnt0 !== 16'd3 || cnt1 !== 16'd2) begin
      errors++;
      $display("FAIL stats_count: cnt0=%0d cnt1=%0d want 3 2", cnt0, cnt1);
    end
    HRESET = 1;
    #1;
    checks++;
    if (cnt0 !== 16'd0 || cnt1 !== 16'd0) begin
      errors++;
      $display("FAIL stats_reset: cnt0=%0d cnt1=%0d want 0 0", cnt0, cnt1);
    end
    tick;
    HRESET = 0;
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_lock;
    test_timeout;
    test_last_cycle_done;
    test_reset_mid_wait;
`ifdef OLED_SCHED_STATS_EN
    test_stats;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
